// File: rtl/uart_rx_pkg.sv
// Shared receiver definitions: FSM states, status bit positions, register offsets
// and the parity helper used when the frame carries a parity bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int ST_VALID = 0;
    localparam int ST_OVR   = 1;
    localparam int ST_FERR  = 2;
    localparam int ST_PERR  = 3;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Small synchronous FIFO with combinational head output; pointers carry one extra
// wrap bit so full/empty come from comparing the MSBs.
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG2;
    localparam int PW    = LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2:0]    wr_ptr_reg;
    logic [LOG2:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[LOG2] != rd_ptr_reg[LOG2]) &&
                   (wr_ptr_reg[LOG2-1:0] == rd_ptr_reg[LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    assign dout = mem[rd_ptr_reg[LOG2-1:0]];

endmodule

// File: rtl/uart_rx.sv
// Console UART receiver: 8N1 deserialiser feeding a small FIFO read over the I/O bus.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7.
module uart_rx #(
    parameter int CLKDIV    = 217,
    parameter int FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       cs,
    input  logic       re,
    input  logic       addr,
    output logic [7:0] rdata,
    output logic       irq
);
    import uart_rx_pkg::*;

    localparam int TW = $clog2(CLKDIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] TIMER_HALF = TW'(CLKDIV / 2);

    logic [1:0]    sync_reg;
    logic [1:0]    flush_reg;
    logic          rx_s;
    logic          rx_prev_reg;
    logic          fall;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic          bit_tick;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shreg_reg;
    logic          push_reg;
    logic          ferr_set_reg;
    logic          perr_set_reg;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_reg;
`endif

    logic          ovr_reg;
    logic          ferr_reg;
    logic          perr_reg;
    logic          data_rd;
    logic          stat_rd;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    status;

    // rx_prev only tracks real samples once the preset synchroniser has flushed,
    // so a line held low across reset release is not mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg    <= 2'b11;
            flush_reg   <= 2'b00;
            rx_prev_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], rx};
            flush_reg   <= {flush_reg[0], 1'b1};
            rx_prev_reg <= flush_reg[1] ? rx_s : 1'b0;
        end
    end

    assign rx_s     = sync_reg[1];
    assign fall     = rx_prev_reg & ~rx_s;
    assign bit_tick = (timer_reg == TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            push_reg     <= 1'b0;
            ferr_set_reg <= 1'b0;
            perr_set_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg  <= 1'b0;
`endif
        end else begin
            push_reg     <= 1'b0;
            ferr_set_reg <= 1'b0;
            perr_set_reg <= 1'b0;
            // Holding the timer at half in IDLE makes the first tick land mid start bit.
            if (state_reg == IDLE) begin
                timer_reg <= TIMER_HALF;
            end else begin
                timer_reg <= bit_tick ? '0 : timer_reg + TW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (fall) state_reg <= START;
                end
                START: begin
                    if (bit_tick) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shreg_reg   <= {rx_s, shreg_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        par_bad_reg  <= even_parity(shreg_reg) ^ rx_s;
                        perr_set_reg <= even_parity(shreg_reg) ^ rx_s;
                        state_reg    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        state_reg    <= IDLE;
`ifdef UART_RX_PARITY_EN
                        push_reg     <= rx_s & ~par_bad_reg;
`else
                        push_reg     <= rx_s;
`endif
                        ferr_set_reg <= ~rx_s;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_rd = cs & re & (addr == REG_DATA) & ~fifo_empty;
    assign stat_rd = cs & re & (addr == REG_STAT);

    // A status read clears the sticky flags, but an error raised that same cycle survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_reg  <= 1'b0;
            ferr_reg <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            ovr_reg  <= (ovr_reg & ~stat_rd) | (push_reg & fifo_full & ~data_rd);
            ferr_reg <= (ferr_reg & ~stat_rd) | ferr_set_reg;
            perr_reg <= (perr_reg & ~stat_rd) | perr_set_reg;
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_reg),
        .pop   (data_rd),
        .din   (shreg_reg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status           = 8'h00;
        status[ST_VALID] = ~fifo_empty;
        status[ST_OVR]   = ovr_reg;
        status[ST_FERR]  = ferr_reg;
        status[ST_PERR]  = perr_reg;
    end

    assign rdata = (addr == REG_STAT) ? status : (fifo_empty ? 8'h00 : fifo_dout);
    assign irq   = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLKDIV=8: directed frames plus random traffic against a queue model.
// Build with UART_RX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_rx;

    localparam int BIT = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       cs = 1'b0;
    logic       re = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] rdata;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit m_ovr = 1'b0;
    bit m_ferr = 1'b0;
    bit m_perr = 1'b0;

    uart_rx #(.CLKDIV(BIT), .FIFO_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .cs    (cs),
        .re    (re),
        .addr  (addr),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drives one frame, one bit per BIT clocks; call at a negedge, returns at a negedge.
    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    // Reference effect of one complete frame on the receive queue and sticky flags.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        bit good;
        good = stop_bit;
`ifdef UART_RX_PARITY_EN
        if (par_flip) begin
            m_perr = 1'b1;
            good = 1'b0;
        end
`endif
        if (!stop_bit) m_ferr = 1'b1;
        if (good) begin
            if (q.size() < 4) q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic send_m(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        send(b, stop_bit, par_flip);
        model_frame(b, stop_bit, par_flip);
    endtask

    // One bus read at a negedge: checks irq and rdata, then applies the read side effect to the model.
    task automatic rd(input logic a, input string tag);
        logic [7:0] exp;
        if (a == 1'b0) exp = (q.size() != 0) ? q[0] : 8'h00;
        else exp = {4'b0, m_perr, m_ferr, m_ovr, q.size() != 0};
        check({tag, "_irq"}, {7'b0, irq}, {7'b0, q.size() != 0});
        cs = 1'b1;
        re = 1'b1;
        addr = a;
        #1;
        check(tag, rdata, exp);
        $display("read addr=%0d rdata=%02h exp=%02h [%s]", a, rdata, exp, tag);
        @(negedge clk);
        cs = 1'b0;
        re = 1'b0;
        addr = 1'b0;
        if (a == 1'b0) begin
            if (q.size() != 0) void'(q.pop_front());
        end else begin
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic sb;
        logic pf;
        int nrd;

        repeat (3) @(negedge clk);
        addr = 1'b0;
        #1 check("rst_data", rdata, 8'h00);
        addr = 1'b1;
        #1 check("rst_stat", rdata, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        addr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte
        send_m(8'h41, 1'b1, 1'b0);
        rd(1'b1, "t1_stat_full");
        rd(1'b0, "t1_data");
        rd(1'b1, "t1_stat_empty");

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        rd(1'b1, "t2_glitch_stat");

        // Five back-to-back frames overflow a depth-4 FIFO
        for (int i = 0; i < 5; i++) send_m(8'h10 + 8'(i), 1'b1, 1'b0);
        rd(1'b1, "t3_stat_ovr");
        rd(1'b1, "t3_stat_clr");
        for (int i = 0; i < 4; i++) rd(1'b0, "t3_data");
        rd(1'b0, "t3_data_empty");
        rd(1'b1, "t3_stat_end");

        // Framing error
        send_m(8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rd(1'b1, "t4_ferr");
        rd(1'b1, "t4_ferr_clr");
        rd(1'b0, "t4_nopush");

        // Pop on the exact edge the next byte is pushed into a full FIFO
        for (int i = 0; i < 4; i++) send_m(8'h90 + 8'(i), 1'b1, 1'b0);
        fork
            send(8'h99, 1'b1, 1'b0);
            begin
                repeat (BIT * NB - 1) @(negedge clk);
                rd(1'b0, "t5_pop");
            end
        join
        model_frame(8'h99, 1'b1, 1'b0);
        rd(1'b1, "t5_stat_noovr");
        for (int i = 0; i < 4; i++) rd(1'b0, "t5_drain");

        // Reset in the middle of a frame with a byte already queued
        send_m(8'h77, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        b = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        reset = 1'b1;
        rx = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        rd(1'b1, "t6_stat_after_rst");
        rd(1'b0, "t6_data_after_rst");
        send_m(8'h3C, 1'b1, 1'b0);
        rd(1'b0, "t6_data_3c");

`ifdef UART_RX_PARITY_EN
        send_m(8'h5A, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        rd(1'b1, "t7_perr");
        rd(1'b0, "t7_nopush");
        send_m(8'h5B, 1'b1, 1'b0);
        rd(1'b0, "t7_good_parity");
`endif

        // Random frames with occasional errors and random read pacing
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            pf = ($urandom_range(0, 5) == 0);
`ifndef UART_RX_PARITY_EN
            pf = 1'b0;
`endif
            send_m(b, sb, pf);
            if (!sb) repeat (4) @(negedge clk);
            nrd = $urandom_range(0, 2);
            for (int k = 0; k < nrd; k++) rd(1'b0, "rnd_data");
            rd(1'b1, "rnd_stat");
        end
        while (q.size() != 0) rd(1'b0, "rnd_drain");
        rd(1'b1, "rnd_stat_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
